// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared state encoding, default data width and clog2 helper
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int DEFAULT_BIT_WIDTH = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4
   } arb_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick : first set request at or above the round-robin pointer, wrapping
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] rr_ptr,
   output logic [PW-1:0] winner,
   output logic          any
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(rr_ptr) + k) % N);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
      any = |req;
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : round-robin sharing of one UART transmitter by NUM_REQ producers
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int BIT_WIDTH    = DEFAULT_BIT_WIDTH,
   parameter int BUSY_TIMEOUT = 16,
   parameter int GAP_CYCLES   = 2,
   localparam int PW          = clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]           ack,
   output logic                         uart_send,
   output logic [BIT_WIDTH-1:0]         uart_tx_reg,
   input  logic                         uart_busy,
   output logic                         idle,
   output logic                         err,
   output logic [PW-1:0]                last_grant
);

   localparam int CMAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
   localparam int CW   = (clog2(CMAX + 1) < 1) ? 1 : clog2(CMAX + 1);

   arb_state_t           state_q;
   logic [NUM_REQ-1:0]   ack_q;
   logic                 send_q;
   logic [BIT_WIDTH-1:0] tx_q;
   logic                 idle_q;
   logic                 err_q;
   logic [PW-1:0]        grant_q;
   logic [PW-1:0]        ptr_q;
   logic [CW-1:0]        cnt_q;

   logic [PW-1:0]        winner;
   logic                 any_req;
   logic [CW-1:0]        cnt_inc_d;
   logic [CW-1:0]        cnt_dec_d;
   logic [PW-1:0]        ptr_d;

   rr_pick #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (ptr_q),
      .winner (winner),
      .any    (any_req)
   );

   assign cnt_inc_d = cnt_q + 1'b1;
   assign cnt_dec_d = cnt_q - 1'b1;
   assign ptr_d     = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ack_q   <= '0;
         send_q  <= 1'b0;
         tx_q    <= '0;
         idle_q  <= 1'b1;
         err_q   <= 1'b0;
         grant_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         ack_q  <= '0;
         send_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (any_req) begin
                  tx_q    <= req_data[winner*BIT_WIDTH +: BIT_WIDTH];
                  ack_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                  grant_q <= winner;
                  ptr_q   <= ptr_d;
                  idle_q  <= 1'b0;
                  state_q <= ST_SEND;
               end
            end
            ST_SEND: begin
               send_q  <= 1'b1;
               cnt_q   <= '0;
               state_q <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               // A stalled UART drops the byte rather than retrying it
               if (uart_busy) begin
                  state_q <= ST_WAIT_DONE;
               end else if (cnt_inc_d == CW'(BUSY_TIMEOUT)) begin
                  err_q   <= 1'b1;
                  idle_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end
            ST_WAIT_DONE: begin
               if (!uart_busy) begin
                  if (GAP_CYCLES == 0) begin
                     idle_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end else begin
                     cnt_q   <= CW'(GAP_CYCLES);
                     state_q <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (cnt_dec_d == '0) begin
                  idle_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_dec_d;
               end
            end
            default: begin
               idle_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack         = ack_q;
   assign uart_send   = send_q;
   assign uart_tx_reg = tx_q;
   assign idle        = idle_q;
   assign err         = err_q;
   assign last_grant  = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// tb_uart_tx_arbiter : randomized bench with round-robin reference and UART model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

   localparam int NUM_REQ      = 4;
   localparam int BIT_WIDTH    = 8;
   localparam int BUSY_TIMEOUT = 16;
   localparam int GAP_CYCLES   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic        uart_busy = 1'b0;
   logic [3:0]  ack;
   logic        uart_send;
   logic [7:0]  uart_tx_reg;
   logic        idle;
   logic        err;
   logic [1:0]  last_grant;

   uart_tx_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .BIT_WIDTH    (BIT_WIDTH),
      .BUSY_TIMEOUT (BUSY_TIMEOUT),
      .GAP_CYCLES   (GAP_CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .uart_send   (uart_send),
      .uart_tx_reg (uart_tx_reg),
      .uart_busy   (uart_busy),
      .idle        (idle),
      .err         (err),
      .last_grant  (last_grant)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         m_ptr   = 0;
   logic [7:0] exp_q[$];
   int         pend    = 0;
   int         hold    = 0;
   int         m_delay = 1;
   int         m_frame = 4;
   bit         stall   = 1'b0;
   logic [3:0] prev_ack = '0;

   function automatic int rr_model(input logic [3:0] r, input int ptr);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   // One clock; protocol checks, then the UART behavioural model reacts.
   task automatic step();
      logic [7:0] e;
      @(posedge clk);
      #1;
      if (prev_ack != 0 || uart_send) begin
         n_tests++;
         if (uart_send !== (prev_ack != 0)) begin
            n_fail++;
            $display("FAIL send_follows_ack: uart_send=%b, ack in previous cycle=%b", uart_send, prev_ack);
         end
      end
      if (ack != 0) begin
         n_tests++;
         if (!$onehot(ack) || prev_ack != 0) begin
            n_fail++;
            $display("FAIL ack_pulse: ack=%b prev=%b, required one-hot single-cycle", ack, prev_ack);
         end
      end
      if (uart_send) begin
         n_tests++;
         if (uart_busy) begin
            n_fail++;
            $display("FAIL send_while_busy: uart_send=1 with uart_busy=1, required busy=0");
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_send: byte %h sent with no pending grant", uart_tx_reg);
         end else begin
            e = exp_q.pop_front();
            if (uart_tx_reg !== e) begin
               n_fail++;
               $display("FAIL send_data: uart_tx_reg=%h, required %h", uart_tx_reg, e);
            end
         end
      end
      prev_ack = ack;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            uart_busy = 1'b1;
            hold = m_frame;
         end
      end else if (uart_busy) begin
         hold--;
         if (hold == 0) uart_busy = 1'b0;
      end
      if (uart_send && !stall) pend = m_delay;
   endtask

   task automatic wait_ack(output int idx);
      int n;
      int ex;
      n = 0;
      idx = -1;
      do begin
         step();
         n++;
      end while (ack == 0 && n < 300);
      n_tests++;
      if (ack == 0) begin
         n_fail++;
         $display("FAIL ack_timeout: no ack within 300 cycles, req=%b", req);
         return;
      end
      ex = rr_model(req, m_ptr);
      if (ex < 0) begin
         n_fail++;
         $display("FAIL spurious_ack: ack=%b with req=0", ack);
         return;
      end
      if (ack !== 4'(1 << ex) || last_grant !== 2'(ex) ||
          uart_tx_reg !== req_data[ex*8 +: 8]) begin
         n_fail++;
         $display("FAIL grant: ack=%b last_grant=%0d tx=%h, required ack=%b grant=%0d tx=%h",
                  ack, last_grant, uart_tx_reg, 4'(1 << ex), ex, req_data[ex*8 +: 8]);
      end
      exp_q.push_back(req_data[ex*8 +: 8]);
      m_ptr = (ex + 1) % NUM_REQ;
      idx = ex;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!idle && n < 300) begin
         step();
         n++;
      end
      n_tests++;
      if (!idle) begin
         n_fail++;
         $display("FAIL idle_timeout: idle=%b after 300 cycles, required 1", idle);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      n_tests++;
      if (ack !== 4'b0 || uart_send !== 1'b0 || uart_tx_reg !== 8'h00 ||
          idle !== 1'b1 || err !== 1'b0 || last_grant !== 2'd0) begin
         n_fail++;
         $display("FAIL %s: ack=%b send=%b tx=%h idle=%b err=%b grant=%0d, required 0/0/00/1/0/0",
                  tag, ack, uart_send, uart_tx_reg, idle, err, last_grant);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      check_reset_outputs("reset_held");
      rst = 1'b1;
      step();
      step();
      check_reset_outputs("reset_released");
   endtask

   task automatic test_fairness();
      int idx;
      req_data = 32'h1312_1110;
      req = 4'hF;
      m_delay = 1;
      m_frame = 3;
      for (int k = 0; k < 8; k++) begin
         wait_ack(idx);
         n_tests++;
         if (last_grant !== 2'(k % 4) || uart_tx_reg !== 8'(8'h10 + k % 4)) begin
            n_fail++;
            $display("FAIL fairness_%0d: grant=%0d tx=%h, required grant=%0d tx=%h",
                     k, last_grant, uart_tx_reg, k % 4, 8'h10 + k % 4);
         end
      end
      req = 4'h0;
      wait_idle();
   endtask

   task automatic test_single();
      int  idx;
      int  n;
      bit  seen_high;
      bit  idle_early;
      req_data[23:16] = 8'h5A;
      req = 4'b0100;
      m_delay = 1;
      m_frame = 100;
      wait_ack(idx);
      n_tests++;
      if (ack !== 4'b0100 || last_grant !== 2'd2 || idle !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ack: ack=%b grant=%0d idle=%b, required 0100/2/0", ack, last_grant, idle);
      end
      req = 4'b0000;
      step();
      n_tests++;
      if (uart_send !== 1'b1 || uart_tx_reg !== 8'h5A) begin
         n_fail++;
         $display("FAIL single_send: send=%b tx=%h, required 1/5a", uart_send, uart_tx_reg);
      end
      seen_high = 1'b0;
      idle_early = 1'b0;
      n = 0;
      while (!(seen_high && !uart_busy) && n < 300) begin
         step();
         n++;
         if (uart_busy) seen_high = 1'b1;
         if (idle) idle_early = 1'b1;
      end
      n_tests++;
      if (idle_early || !seen_high) begin
         n_fail++;
         $display("FAIL single_frame: idle during frame=%b busy seen=%b, required 0/1", idle_early, seen_high);
      end
      n = 0;
      while (!idle && n < 20) begin
         step();
         n++;
      end
      n_tests++;
      if (n != GAP_CYCLES + 1) begin
         n_fail++;
         $display("FAIL single_gap: idle after %0d cycles of busy low, required %0d", n, GAP_CYCLES + 1);
      end
   endtask

   task automatic test_wrap();
      int idx;
      req_data = {8'hC3, 8'h00, 8'h00, 8'h3C};
      req = 4'b1001;
      m_frame = 4;
      wait_ack(idx);
      n_tests++;
      if (last_grant !== 2'd3 || uart_tx_reg !== 8'hC3) begin
         n_fail++;
         $display("FAIL wrap_first: grant=%0d tx=%h, required 3/c3", last_grant, uart_tx_reg);
      end
      wait_ack(idx);
      n_tests++;
      if (last_grant !== 2'd0 || uart_tx_reg !== 8'h3C) begin
         n_fail++;
         $display("FAIL wrap_second: grant=%0d tx=%h, required 0/3c", last_grant, uart_tx_reg);
      end
      req = 4'b0000;
      wait_idle();
   endtask

   task automatic test_timeout();
      int idx;
      int n;
      bit ack_seen;
      stall = 1'b1;
      req_data[15:8] = 8'hE7;
      req = 4'b0010;
      wait_ack(idx);
      step();
      n = 0;
      ack_seen = 1'b0;
      while (!err && n < 100) begin
         step();
         n++;
         if (ack != 0) ack_seen = 1'b1;
      end
      n_tests++;
      if (n != BUSY_TIMEOUT || ack_seen || idle !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout: err after %0d cycles ack_seen=%b idle=%b, required %0d/0/1",
                  n, ack_seen, idle, BUSY_TIMEOUT);
      end
      stall = 1'b0;
      m_frame = 3;
      wait_ack(idx);
      req = 4'b0000;
      wait_idle();
      n_tests++;
      if (err !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL timeout_recovery: err=%b pending=%0d, required 0/0", err, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int idx;
      req_data[15:0] = 16'hB2A1;
      req = 4'b0011;
      m_frame = 50;
      wait_ack(idx);
      req = 4'b0000;
      repeat (5) step();
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("reset_mid_frame");
      uart_busy = 1'b0;
      pend = 0;
      hold = 0;
      exp_q.delete();
      m_ptr = 0;
      prev_ack = '0;
      step();
      step();
      rst = 1'b1;
      m_frame = 4;
      req = 4'b0011;
      wait_ack(idx);
      n_tests++;
      if (last_grant !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_ptr: grant=%0d after reset, required 0", last_grant);
      end
      req = 4'b0000;
      wait_idle();
   endtask

   task automatic test_random();
      int idx;
      req = 4'($urandom_range(1, 15));
      req_data = $urandom;
      for (int it = 0; it < 30; it++) begin
         m_delay = $urandom_range(1, 3);
         m_frame = $urandom_range(1, 12);
         wait_ack(idx);
         if (idx >= 0) begin
            if ($urandom_range(0, 1) == 0) req[idx] = 1'b0;
            else req_data[idx*8 +: 8] = 8'($urandom);
         end
         if (req == 0) begin
            req = 4'($urandom_range(1, 15));
            req_data = $urandom;
         end
      end
      req = 4'b0000;
      wait_idle();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL random_drain: %0d bytes never sent, required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_single();
      test_wrap();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
